// File: rtl/huffman_decoder_pkg.sv
// Shared types and constants for the Huffman stream decoder.
// Holds the FSM state encoding and the codebook entry layout.
package huffman_pkg;

  localparam int WORD_BITS    = 32;
  localparam int HEADER_BITS  = 16;
  localparam int MAX_CODE_LEN = 16;
  localparam int CODE_LEN_W   = $clog2(MAX_CODE_LEN + 1);

  typedef enum logic [2:0] {
    LOAD,
    HEADER,
    DECODE,
    DONE,
    ERROR
  } state_t;

  typedef struct packed {
    logic [31:0] symbol;
    logic [7:0]  length;
    logic [7:0]  character;
  } entry_t;

endpackage

// File: rtl/huffman_decoder_code_matcher.sv
// Parallel compare of the accumulated code against every codebook entry.
// The lowest matching index wins.
module huffman_code_matcher
  import huffman_pkg::*;
#(
  parameter int SYMBOLS_COUNT = 28
) (
  input  entry_t                  tbl [SYMBOLS_COUNT],
  input  logic [MAX_CODE_LEN-1:0] code,
  input  logic [CODE_LEN_W-1:0]   len,
  output logic                    hit,
  output logic [7:0]              hit_char
);

  logic [31:0] mask;
  logic [31:0] code_ext;

  always_comb begin
    mask     = '0;
    code_ext = 32'(code);
    hit      = 1'b0;
    hit_char = '0;
    for (int b = 0; b < 32; b++) begin
      mask[b] = (b < int'(len));
    end
    // Scan high to low so the lowest index overwrites last.
    for (int i = SYMBOLS_COUNT - 1; i >= 0; i--) begin
      if (len != '0 &&
          tbl[i].length == 8'(len) &&
          ((code_ext ^ tbl[i].symbol) & mask) == '0) begin
        hit      = 1'b1;
        hit_char = tbl[i].character;
      end
    end
  end

endmodule

// File: rtl/huffman_decoder.sv
// Huffman stream decoder: one payload bit per clock, valid/ready I/O.
// Optional HUFFMAN_DECODER_LOG_EN adds a {state, charCount} log port.
module huffman_decoder
  import huffman_pkg::*;
#(
  parameter int SYMBOLS_COUNT = 28
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        manualReset,
  input  logic        tableWrite,
  input  logic [31:0] symbol,
  input  logic [7:0]  symbolLength,
  input  logic [7:0]  character,
  input  logic        tableLoaded,
  input  logic [31:0] wordIn,
  input  logic        wordValid,
  output logic        wordReady,
  output logic [7:0]  charOut,
  output logic        charValid,
  input  logic        charReady,
  output logic        done,
  output logic        error
`ifdef HUFFMAN_DECODER_LOG_EN
  ,
  output logic [15:0] log
`endif
);

  localparam int PTR_W = $clog2(SYMBOLS_COUNT + 1);
  localparam int IDX_W = $clog2(SYMBOLS_COUNT);

  state_t                  state_q, state_d;
  entry_t                  tbl_q [SYMBOLS_COUNT];
  entry_t                  tbl_d [SYMBOLS_COUNT];
  logic [PTR_W-1:0]        wptr_q, wptr_d;
  logic [HEADER_BITS-1:0]  rem_q, rem_d;
  logic [WORD_BITS-1:0]    buf_q, buf_d;
  logic [5:0]              cnt_q, cnt_d;
  logic [MAX_CODE_LEN-1:0] acc_q, acc_d, acc_nx;
  logic [CODE_LEN_W-1:0]   len_q, len_d, len_nx;
  logic [7:0]              char_q, char_d;
  logic                    cv_q, cv_d;
  logic                    word_rdy;
  logic                    stall;
  logic                    hit;
  logic [7:0]              hit_char;

  assign acc_nx = {acc_q[MAX_CODE_LEN-2:0], buf_q[WORD_BITS-1]};
  assign len_nx = len_q + 1'b1;
  assign stall  = cv_q && !charReady;

  huffman_code_matcher #(
    .SYMBOLS_COUNT(SYMBOLS_COUNT)
  ) u_match (
    .tbl     (tbl_q),
    .code    (acc_nx),
    .len     (len_nx),
    .hit     (hit),
    .hit_char(hit_char)
  );

  always_comb begin
    state_d  = state_q;
    tbl_d    = tbl_q;
    wptr_d   = wptr_q;
    rem_d    = rem_q;
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    len_d    = len_q;
    char_d   = char_q;
    cv_d     = cv_q;
    word_rdy = 1'b0;
    if (cv_q && charReady) cv_d = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (tableWrite && wptr_q < PTR_W'(SYMBOLS_COUNT)) begin
          tbl_d[wptr_q[IDX_W-1:0]] = '{symbol, symbolLength, character};
          wptr_d = wptr_q + 1'b1;
        end
        if (tableLoaded) state_d = HEADER;
      end
      HEADER: begin
        word_rdy = 1'b1;
        if (wordValid) begin
          rem_d   = wordIn[31:16];
          buf_d   = {wordIn[15:0], 16'h0000};
          cnt_d   = 6'd16;
          state_d = (wordIn[31:16] == '0) ? DONE : DECODE;
        end
      end
      DECODE: begin
        if (rem_q == '0) begin
          // Last code already matched; leave once its char is taken.
          if (!stall) begin
            state_d = DONE;
            cv_d    = 1'b0;
          end
        end else if (cnt_q == '0) begin
          word_rdy = !stall;
          if (wordValid && !stall) begin
            buf_d = wordIn;
            cnt_d = 6'd32;
          end
        end else if (!stall) begin
          buf_d = buf_q << 1;
          cnt_d = cnt_q - 1'b1;
          rem_d = rem_q - 1'b1;
          if (hit) begin
            char_d = hit_char;
            cv_d   = 1'b1;
            acc_d  = '0;
            len_d  = '0;
          end else if (len_nx == CODE_LEN_W'(MAX_CODE_LEN) ||
                       rem_q == HEADER_BITS'(1)) begin
            state_d = ERROR;
            cv_d    = 1'b0;
          end else begin
            acc_d = acc_nx;
            len_d = len_nx;
          end
        end
      end
      DONE, ERROR: begin
        cv_d = 1'b0;
      end
      default: state_d = LOAD;
    endcase
    if (manualReset) begin
      state_d  = LOAD;
      for (int i = 0; i < SYMBOLS_COUNT; i++) tbl_d[i] = '0;
      wptr_d   = '0;
      rem_d    = '0;
      buf_d    = '0;
      cnt_d    = '0;
      acc_d    = '0;
      len_d    = '0;
      char_d   = '0;
      cv_d     = 1'b0;
      word_rdy = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= LOAD;
      for (int i = 0; i < SYMBOLS_COUNT; i++) tbl_q[i] <= '0;
      wptr_q  <= '0;
      rem_q   <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      len_q   <= '0;
      char_q  <= '0;
      cv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tbl_q   <= tbl_d;
      wptr_q  <= wptr_d;
      rem_q   <= rem_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      len_q   <= len_d;
      char_q  <= char_d;
      cv_q    <= cv_d;
    end
  end

  assign wordReady = word_rdy;
  assign charOut   = char_q;
  assign charValid = cv_q;
  assign done      = (state_q == DONE);
  assign error     = (state_q == ERROR);

`ifdef HUFFMAN_DECODER_LOG_EN
  logic [11:0] cc_q, cc_d;

  always_comb begin
    cc_d = cc_q;
    if (cv_q && charReady) cc_d = cc_q + 1'b1;
    if (manualReset) cc_d = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cc_q <= '0;
    else       cc_q <= cc_d;
  end

  assign log = {1'b0, state_q, cc_q};
`endif

endmodule

// File: tb/tb_huffman_decoder.sv
// Directed self-checking bench for huffman_decoder.
// Covers reset, single/multi-word decode, back-pressure, errors, mid-run reset.
module tb_huffman_decoder;

  logic        clock = 1'b0;
  logic        reset;
  logic        manualReset;
  logic        tableWrite;
  logic [31:0] symbol;
  logic [7:0]  symbolLength;
  logic [7:0]  character;
  logic        tableLoaded;
  logic [31:0] wordIn;
  logic        wordValid;
  logic        wordReady;
  logic [7:0]  charOut;
  logic        charValid;
  logic        charReady;
  logic        done;
  logic        error;
`ifdef HUFFMAN_DECODER_LOG_EN
  logic [15:0] log_w;
`endif

  int passed = 0;
  int total  = 0;

  logic [7:0]  got [$];
  int          n_words = 0;
  int          n_valid = 0;
  logic [31:0] wq [4];
  int          nw;
  logic        feed_to;

  always #5 clock = ~clock;

  huffman_decoder dut (
    .clock       (clock),
    .reset       (reset),
    .manualReset (manualReset),
    .tableWrite  (tableWrite),
    .symbol      (symbol),
    .symbolLength(symbolLength),
    .character   (character),
    .tableLoaded (tableLoaded),
    .wordIn      (wordIn),
    .wordValid   (wordValid),
    .wordReady   (wordReady),
    .charOut     (charOut),
    .charValid   (charValid),
    .charReady   (charReady),
    .done        (done),
    .error       (error)
`ifdef HUFFMAN_DECODER_LOG_EN
    ,
    .log         (log_w)
`endif
  );

  always @(negedge clock) begin
    if (!reset && !manualReset) begin
      if (charValid && charReady) got.push_back(charOut);
      if (wordValid && wordReady) n_words++;
      if (charValid) n_valid++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; manualReset = 1'b0;
    tableWrite = 1'b0; tableLoaded = 1'b0;
    symbol = '0; symbolLength = '0; character = '0;
    wordIn = '0; wordValid = 1'b0; charReady = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic write_entry(input logic [31:0] s, input logic [7:0] l,
                             input logic [7:0] c);
    symbol = s; symbolLength = l; character = c; tableWrite = 1'b1;
    tick();
    tableWrite = 1'b0;
  endtask

  task automatic load_ate();
    write_entry(32'd14, 8'd4, 8'd65);
    write_entry(32'd0,  8'd3, 8'd84);
    write_entry(32'd4,  8'd3, 8'd69);
    tableLoaded = 1'b1; tick(); tableLoaded = 1'b0;
  endtask

  task automatic load_a();
    write_entry(32'd14, 8'd4, 8'd65);
    tableLoaded = 1'b1; tick(); tableLoaded = 1'b0;
  endtask

  task automatic feed();
    bit ok;
    feed_to = 1'b0;
    for (int i = 0; i < nw; i++) begin
      wordIn = wq[i]; wordValid = 1'b1; ok = 0;
      for (int c = 0; c < 200 && !ok; c++) begin
        @(negedge clock);
        if (wordReady) ok = 1;
      end
      if (!ok) feed_to = 1'b1;
      tick();
    end
    wordValid = 1'b0;
  endtask

  task automatic wait_end(output bit ok);
    ok = 0;
    for (int c = 0; c < 500 && !ok; c++) begin
      @(negedge clock);
      if (done || error) ok = 1;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (wordReady !== 1'b0) $display("FAIL rst_wordReady got %b want 0", wordReady); else passed++;
    total++; if (charValid !== 1'b0) $display("FAIL rst_charValid got %b want 0", charValid); else passed++;
    total++; if (charOut !== 8'd0) $display("FAIL rst_charOut got %0d want 0", charOut); else passed++;
    total++; if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done); else passed++;
    total++; if (error !== 1'b0) $display("FAIL rst_error got %b want 0", error); else passed++;
    tick(); tick();
    total++; if (wordReady !== 1'b0) $display("FAIL load_wordReady got %b want 0", wordReady); else passed++;
  endtask

  task automatic test_ate();
    logic [7:0] exp_c [3];
    logic [7:0] c;
    int base, bw;
    bit ok;
    exp_c = '{8'd65, 8'd84, 8'd69};
    apply_reset();
    base = got.size(); bw = n_words;
    load_ate();
    wq[0] = 32'h000AE100; nw = 1;
    feed();
    wait_end(ok);
    total++; if (!ok) $display("FAIL ate_timeout got 0 want 1"); else passed++;
    total++; if (feed_to !== 1'b0) $display("FAIL ate_feed got %b want 0", feed_to); else passed++;
    total++; if (got.size() - base != 3) $display("FAIL ate_count got %0d want 3", got.size() - base); else passed++;
    for (int i = 0; i < 3; i++) begin
      c = (base + i < got.size()) ? got[base + i] : 8'hxx;
      total++; if (c !== exp_c[i]) $display("FAIL ate_char%0d got %0d want %0d", i, c, exp_c[i]); else passed++;
    end
    total++; if (done !== 1'b1) $display("FAIL ate_done got %b want 1", done); else passed++;
    total++; if (error !== 1'b0) $display("FAIL ate_error got %b want 0", error); else passed++;
    total++; if (n_words - bw != 1) $display("FAIL ate_words got %0d want 1", n_words - bw); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] c;
    int base, bw;
    bit ok;
    apply_reset();
    base = got.size(); bw = n_words;
    load_ate();
    wq[0] = 32'h0014EEEE; wq[1] = 32'hE0000000; nw = 2;
    feed();
    wait_end(ok);
    total++; if (!ok) $display("FAIL b2b_timeout got 0 want 1"); else passed++;
    total++; if (got.size() - base != 5) $display("FAIL b2b_count got %0d want 5", got.size() - base); else passed++;
    for (int i = 0; i < 5; i++) begin
      c = (base + i < got.size()) ? got[base + i] : 8'hxx;
      total++; if (c !== 8'd65) $display("FAIL b2b_char%0d got %0d want 65", i, c); else passed++;
    end
    total++; if (n_words - bw != 2) $display("FAIL b2b_words got %0d want 2", n_words - bw); else passed++;
    total++; if (done !== 1'b1 || error !== 1'b0) $display("FAIL b2b_end got done=%b error=%b want 1/0", done, error); else passed++;
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_c [3];
    logic [7:0] c;
    int base;
    bit ok, seen;
    exp_c = '{8'd65, 8'd84, 8'd69};
    apply_reset();
    charReady = 1'b0;
    base = got.size();
    load_ate();
    wq[0] = 32'h000AE100; nw = 1;
    feed();
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      if (charValid) seen = 1; else tick();
    end
    total++; if (!seen) $display("FAIL bp_first_valid got 0 want 1"); else passed++;
    for (int k = 0; k < 5; k++) begin
      tick();
      total++; if (charOut !== 8'd65 || charValid !== 1'b1) $display("FAIL bp_hold%0d got %0d/%b want 65/1", k, charOut, charValid); else passed++;
    end
    total++; if (wordReady !== 1'b0) $display("FAIL bp_wordReady got %b want 0", wordReady); else passed++;
    total++; if (got.size() != base) $display("FAIL bp_no_accept got %0d want %0d", got.size(), base); else passed++;
    charReady = 1'b1;
    wait_end(ok);
    total++; if (got.size() - base != 3) $display("FAIL bp_count got %0d want 3", got.size() - base); else passed++;
    for (int i = 0; i < 3; i++) begin
      c = (base + i < got.size()) ? got[base + i] : 8'hxx;
      total++; if (c !== exp_c[i]) $display("FAIL bp_char%0d got %0d want %0d", i, c, exp_c[i]); else passed++;
    end
    total++; if (!ok || done !== 1'b1) $display("FAIL bp_done got %b want 1", done); else passed++;
  endtask

  task automatic test_invalid_tail();
    int base, bv;
    bit ok;
    apply_reset();
    base = got.size(); bv = n_valid;
    load_a();
    wq[0] = 32'h00040000; nw = 1;
    feed();
    wait_end(ok);
    total++; if (!ok || error !== 1'b1) $display("FAIL inv_error got %b want 1", error); else passed++;
    total++; if (done !== 1'b0) $display("FAIL inv_done got %b want 0", done); else passed++;
    total++; if (got.size() != base) $display("FAIL inv_chars got %0d want 0", got.size() - base); else passed++;
    total++; if (n_valid != bv) $display("FAIL inv_valid got %0d want 0", n_valid - bv); else passed++;
    tick(); tick();
    total++; if (error !== 1'b1 || wordReady !== 1'b0) $display("FAIL inv_sticky got %b/%b want 1/0", error, wordReady); else passed++;
  endtask

  task automatic test_empty();
    int bv;
    bit ok;
    apply_reset();
    bv = n_valid;
    load_ate();
    wq[0] = 32'h00000000; nw = 1;
    feed();
    wait_end(ok);
    total++; if (!ok || done !== 1'b1) $display("FAIL empty_done got %b want 1", done); else passed++;
    total++; if (error !== 1'b0) $display("FAIL empty_error got %b want 0", error); else passed++;
    total++; if (n_valid != bv) $display("FAIL empty_valid got %0d want 0", n_valid - bv); else passed++;
  endtask

  task automatic test_mid_reset();
    logic [7:0] c;
    int base;
    bit ok;
    apply_reset();
    load_ate();
    wq[0] = 32'h0014EEEE; wq[1] = 32'hE0000000; nw = 2;
    feed();
    tick();
    manualReset = 1'b1;
    tick();
    manualReset = 1'b0;
    total++; if (wordReady !== 1'b0) $display("FAIL mr_wordReady got %b want 0", wordReady); else passed++;
    total++; if (charValid !== 1'b0) $display("FAIL mr_charValid got %b want 0", charValid); else passed++;
    total++; if (charOut !== 8'd0) $display("FAIL mr_charOut got %0d want 0", charOut); else passed++;
    total++; if (done !== 1'b0 || error !== 1'b0) $display("FAIL mr_flags got %b/%b want 0/0", done, error); else passed++;
    tick(); tick();
    total++; if (wordReady !== 1'b0) $display("FAIL mr_load_state got %b want 0", wordReady); else passed++;
    base = got.size();
    load_ate();
    feed();
    wait_end(ok);
    total++; if (got.size() - base != 5) $display("FAIL mr_count got %0d want 5", got.size() - base); else passed++;
    for (int i = 0; i < 5; i++) begin
      c = (base + i < got.size()) ? got[base + i] : 8'hxx;
      total++; if (c !== 8'd65) $display("FAIL mr_char%0d got %0d want 65", i, c); else passed++;
    end
    total++; if (!ok || done !== 1'b1) $display("FAIL mr_done got %b want 1", done); else passed++;
  endtask

  initial begin
    test_reset();
    test_ate();
    test_back_to_back();
    test_backpressure();
    test_invalid_tail();
    test_empty();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
